sizer_resp_misr: RTL and testbench

- Downstream response-capture stage for the sizer combinational core.
- Samples the core's two primary outputs, nx22 and nx23, under a valid/ready handshake.
- Compacts the sampled responses into a multiple-input signature register (MISR) over a programmed number of patterns.
- Counts how many captured responses had each output high.
- Reports the final signature and counts with a done flag, for timing-closure silicon/sim sign-off.

---
 rtl/sizer_resp_misr_if.sv | 22 ++
 rtl/sizer_resp_misr.sv | 133 +++++++++++++
 tb/tb_sizer_resp_misr.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sizer_resp_misr_if.sv
// Response handshake between the sizer core sampler and the MISR capture stage.
// Carries the two core outputs with a valid/ready pair.
interface sizer_resp_misr_if;
  logic in_valid;
  logic in_ready;
  logic nx22;
  logic nx23;

  modport master (
    output in_valid,
    output nx22,
    output nx23,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  nx22,
    input  nx23,
    output in_ready
  );
endinterface

// File: rtl/sizer_resp_misr.sv
// Captures nx22/nx23 responses and compacts them into a MISR with per-output one counts.
// Final result 2 edges after last accept; in_ready only while a session still needs responses.
module sizer_resp_misr #(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021,
  parameter logic [SIG_W-1:0] SEED  = 16'hFFFF,
  parameter int               CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [CNT_W-1:0]   i_num_patterns,
  sizer_resp_misr_if.slave   resp,
  output logic               o_busy,
  output logic               o_done,
  output logic [SIG_W-1:0]   o_signature,
  output logic [CNT_W-1:0]   o_ones22,
  output logic [CNT_W-1:0]   o_ones23,
  output logic [CNT_W-1:0]   o_accepted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_accepted;
  logic [CNT_W-1:0] r_ones22;
  logic [CNT_W-1:0] r_ones23;
  logic [SIG_W-1:0] r_sig;
  logic [1:0]       r_cap;
  logic             r_cap_vld;

  logic             w_start_ok;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_last;
  logic [SIG_W-1:0] w_sig_nxt;

  assign w_start_ok = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_in_ready = (r_state == S_RUN) && (r_accepted < r_target);
  assign w_accept   = resp.in_valid && w_in_ready;
  assign w_last     = w_accept && ((r_accepted + CNT_W'(1)) == r_target);

  // Captured pair enters the low bits: nx22 on bit 0, nx23 on bit 1.
  assign w_sig_nxt = {r_sig[SIG_W-2:0], 1'b0}
                   ^ (r_sig[SIG_W-1] ? POLY : '0)
                   ^ {{(SIG_W-2){1'b0}}, r_cap};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_ok) begin
          w_state_nxt = (i_num_patterns == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target   <= '0;
      r_accepted <= '0;
      r_ones22   <= '0;
      r_ones23   <= '0;
    end else if (w_start_ok) begin
      r_target   <= i_num_patterns;
      r_accepted <= '0;
      r_ones22   <= '0;
      r_ones23   <= '0;
    end else if (w_accept) begin
      r_accepted <= r_accepted + CNT_W'(1);
      r_ones22   <= r_ones22 + CNT_W'(resp.nx22);
      r_ones23   <= r_ones23 + CNT_W'(resp.nx23);
    end
  end

  // One-stage pipeline: a response is captured on its accept edge and folded in on the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig     <= SEED;
      r_cap     <= 2'b00;
      r_cap_vld <= 1'b0;
    end else if (w_start_ok) begin
      r_sig     <= SEED;
      r_cap     <= 2'b00;
      r_cap_vld <= 1'b0;
    end else begin
      if (r_cap_vld) begin
        r_sig <= w_sig_nxt;
      end
      r_cap_vld <= w_accept;
      if (w_accept) begin
        r_cap <= {resp.nx23, resp.nx22};
      end
    end
  end

  assign resp.in_ready = w_in_ready;
  assign o_busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign o_done        = (r_state == S_DONE);
  assign o_signature   = r_sig;
  assign o_ones22      = r_ones22;
  assign o_ones23      = r_ones23;
  assign o_accepted    = r_accepted;

endmodule

// File: tb/tb_sizer_resp_misr.sv
// Self-checking bench for sizer_resp_misr: table-driven sessions with a result scoreboard,
// plus hand sequences for reset mid-session and ignored inputs.
module tb_sizer_resp_misr;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] num_patterns;
  logic        busy;
  logic        done;
  logic [15:0] signature;
  logic [15:0] ones22;
  logic [15:0] ones23;
  logic [15:0] accepted;

  sizer_resp_misr_if resp_if ();

  sizer_resp_misr dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (start),
    .i_num_patterns (num_patterns),
    .resp           (resp_if),
    .o_busy         (busy),
    .o_done         (done),
    .o_signature    (signature),
    .o_ones22       (ones22),
    .o_ones23       (ones23),
    .o_accepted     (accepted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] n;
    logic [15:0] resp;   // response i is resp[2*i +: 2] = {nx23, nx22}
    logic [15:0] sig;
    logic [15:0] o22;
    logic [15:0] o23;
    bit          mid_start;
  } vec_t;

  typedef struct {
    logic [15:0] sig;
    logic [15:0] o22;
    logic [15:0] o23;
    logic [15:0] acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] n, input logic [15:0] r);
    exp_t e;
    logic [15:0] s;
    logic [1:0]  b;
    s = 16'hFFFF;
    e.o22 = '0;
    e.o23 = '0;
    for (int i = 0; i < int'(n); i++) begin
      b = r[2*i +: 2];
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'b0, b};
      e.o22 += 16'(b[0]);
      e.o23 += 16'(b[1]);
    end
    e.sig = s;
    e.acc = n;
    return e;
  endfunction

  task automatic wait_done(input string name, input int exp_lat);
    int lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: done never rose, waited %0d cycles", name, lat);
    end else begin
      chk({name, "_latency"}, lat, exp_lat);
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    exp_t e, got;
    e.sig = v.sig;
    e.o22 = v.o22;
    e.o23 = v.o23;
    e.acc = v.n;
    exp_q.push_back(e);

    @(negedge clk);
    start        = 1'b1;
    num_patterns = v.n;
    @(negedge clk);
    start        = 1'b0;
    num_patterns = 16'h0;

    if (v.n == 0) begin
      chk({name, "_in_ready_zero"}, resp_if.in_ready, 1'b0);
      wait_done(name, 0);
    end else begin
      for (int i = 0; i < int'(v.n); i++) begin
        chk({name, "_in_ready"}, resp_if.in_ready, 1'b1);
        chk({name, "_acc_step"}, accepted, i);
        start = (v.mid_start && i == 1);
        num_patterns = (v.mid_start && i == 1) ? 16'd1 : 16'd0;
        resp_if.in_valid = 1'b1;
        {resp_if.nx23, resp_if.nx22} = v.resp[2*i +: 2];
        @(negedge clk);
      end
      // DRAIN cycle: extra valid must be ignored.
      start            = 1'b0;
      num_patterns     = 16'h0;
      chk({name, "_drain_rdy"}, resp_if.in_ready, 1'b0);
      chk({name, "_drain_done"}, done, 1'b0);
      chk({name, "_drain_busy"}, busy, 1'b1);
      resp_if.nx22     = 1'b1;
      resp_if.nx23     = 1'b1;
      @(negedge clk);
      resp_if.in_valid = 1'b0;
      wait_done(name, 0);
    end

    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard: queue empty, expected one entry", name);
    end else begin
      got = exp_q.pop_front();
      chk({name, "_sig"}, signature, got.sig);
      chk({name, "_ones22"}, ones22, got.o22);
      chk({name, "_ones23"}, ones23, got.o23);
      chk({name, "_accepted"}, accepted, got.acc);
      chk({name, "_busy_done"}, busy, 1'b0);
    end
    @(negedge clk);
    chk({name, "_done_held"}, done, 1'b1);
  endtask

  vec_t vecs[6];

  initial begin
    vec_t rv;
    exp_t me;

    vecs[0] = '{n: 16'd1, resp: 16'h0000, sig: 16'hEFDF, o22: 16'd0, o23: 16'd0, mid_start: 1'b0};
    vecs[1] = '{n: 16'd1, resp: 16'h0003, sig: 16'hEFDC, o22: 16'd1, o23: 16'd1, mid_start: 1'b0};
    vecs[2] = '{n: 16'd2, resp: 16'h0000, sig: 16'hCF9F, o22: 16'd0, o23: 16'd0, mid_start: 1'b0};
    vecs[3] = '{n: 16'd0, resp: 16'h0000, sig: 16'hFFFF, o22: 16'd0, o23: 16'd0, mid_start: 1'b0};
    // responses 01, 10, 11 in order
    vecs[4] = '{n: 16'd3, resp: 16'h0039, sig: 16'h8F1C, o22: 16'd2, o23: 16'd2, mid_start: 1'b0};
    vecs[5] = '{n: 16'd3, resp: 16'h0039, sig: 16'h8F1C, o22: 16'd2, o23: 16'd2, mid_start: 1'b1};

    rst_n            = 1'b0;
    start            = 1'b0;
    num_patterns     = 16'h0;
    resp_if.in_valid = 1'b0;
    resp_if.nx22     = 1'b0;
    resp_if.nx23     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Valid while idle is ignored.
    resp_if.in_valid = 1'b1;
    resp_if.nx22     = 1'b1;
    @(negedge clk);
    resp_if.in_valid = 1'b0;
    resp_if.nx22     = 1'b0;
    @(negedge clk);
    chk("rst_sig", signature, 16'hFFFF);
    chk("rst_ones22", ones22, 16'h0);
    chk("rst_ones23", ones23, 16'h0);
    chk("rst_accepted", accepted, 16'h0);
    chk("rst_in_ready", resp_if.in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);

    for (int i = 0; i < 6; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset in the middle of a 4-pattern session.
    @(negedge clk);
    start        = 1'b1;
    num_patterns = 16'd4;
    @(negedge clk);
    start            = 1'b0;
    resp_if.in_valid = 1'b1;
    resp_if.nx22     = 1'b1;
    resp_if.nx23     = 1'b1;
    repeat (2) @(negedge clk);
    resp_if.in_valid = 1'b0;
    chk("mid_accepted", accepted, 16'd2);
    chk("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_sig", signature, 16'hFFFF);
    chk("arst_accepted", accepted, 16'h0);
    chk("arst_ones22", ones22, 16'h0);
    chk("arst_ones23", ones23, 16'h0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_in_ready", resp_if.in_ready, 1'b0);
    @(negedge clk);
    rst_n            = 1'b1;
    resp_if.nx22     = 1'b0;
    resp_if.nx23     = 1'b0;
    run_vec("post_rst", vecs[0]);

    // Random sessions checked against the bench model.
    for (int k = 0; k < 4; k++) begin
      rv.n         = 16'($urandom_range(1, 8));
      rv.resp      = 16'($urandom);
      rv.mid_start = 1'b0;
      me           = model(rv.n, rv.resp);
      rv.sig       = me.sig;
      rv.o22       = me.o22;
      rv.o23       = me.o23;
      run_vec($sformatf("rand%0d", k), rv);
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
